image_fetch: RTL and testbench
==============================

Name: image_fetch

Overview:
- Scan-out stage directly upstream of the single-port frame SRAM: turns VGA timing (frame start, display-active) into SRAM read addresses for one of several stored images.
- Absorbs the SRAM's 1-cycle registered read and emits an aligned, registered pixel stream to the VGA colour output.
- Each stored pixel is replicated 2^SCALE_SHIFT times in x and y; pixels outside the scaled image get a border colour.

Parameters:
- ADDR_WIDTH, 17, SRAM address width; must cover NUM_IMAGES*IMG_W*IMG_H.
- DATA_WIDTH, 12, pixel width (RGB444).
- IMG_W, 160, stored image width in pixels.
- IMG_H, 120, stored image height in lines.
- NUM_IMAGES, 4, images stored back-to-back from address 0; image k base = k*IMG_W*IMG_H.
- SEL_WIDTH, 2, width of image select.
- SCALE_SHIFT, 2, log2 replication factor (160x120 -> 640x480).
- BORDER_COLOR, 12'h000, colour outside image or for an invalid select.

Ports:
- i_clk  in  1  system/pixel clock.
- i_rst_n  in  1  synchronous active-low reset.
- i_frame_start  in  1  one-cycle pulse before the first active line of a frame.
- i_active  in  1  display-enable; high for each visible pixel.
- i_img_sel  in  SEL_WIDTH  requested image; sampled only on i_frame_start.
- i_mirror  in  1  horizontal mirror request; sampled on i_frame_start (used only with the optional feature).
- o_addr  out  ADDR_WIDTH  SRAM i_addr.
- o_write  out  1  SRAM i_write; constant 0.
- i_sram_data  in  DATA_WIDTH  SRAM o_data.
- o_pixel  out  DATA_WIDTH  registered pixel colour.
- o_pixel_valid  out  1  o_pixel corresponds to an active pixel.

Behaviour:
- Reset (i_rst_n=0 at a clock edge):
  - o_addr=0, o_pixel=0, o_pixel_valid=0.
  - All counters and pipeline registers cleared; state=S_IDLE.
  - Applies mid-frame too: no valid pixels until the next i_frame_start.
- States:
  - S_IDLE -> S_LINE on i_frame_start.
  - S_LINE -> S_ACTIVE when i_active=1.
  - S_ACTIVE -> S_LINE when i_active falls; the line counters advance on that transition.
  - i_frame_start in any state: latch sel/mirror, clear row/vsub, go to S_LINE. This takes priority over a simultaneous i_active fall.
- Horizontal:
  - hsub counts 0..2^S-1; col increments when hsub wraps.
  - col saturates at IMG_W (border region); o_addr holds its last value.
  - col and hsub are cleared on entry to S_ACTIVE.
- Vertical:
  - At end of each line, vsub increments; on wrap, row increments and line_base += IMG_W.
  - row saturates at IMG_H (border).
  - On frame start, line_base = sel*IMG_W*IMG_H.
- Address:
  - o_addr <= line_base + col, registered.
  - All arithmetic is done at ADDR_WIDTH; no wrap is possible for legal parameters.
- Latency:
  - i_active sampled at cycle N -> o_addr at N+1 -> SRAM data at N+2 -> o_pixel/o_pixel_valid at N+3. Fixed 3 cycles.
  - The upstream timing generator delays hsync/vsync by 3 cycles.
- Border flag:
  - Computed at cycle N and pipelined 2 stages alongside active.
  - o_pixel = border ? BORDER_COLOR : i_sram_data when valid; 0 otherwise.
- Invalid select (latched sel >= NUM_IMAGES): whole frame is BORDER_COLOR; o_addr stays 0.
- i_active high before any frame_start (S_IDLE): ignored, o_pixel_valid=0.

Optional Feature:
- IMG_FETCH_MIRROR_EN.
- Defined: when the latched mirror bit=1, address column = IMG_W-1-col; border, latency and vertical behaviour are unchanged.
- Undefined: i_mirror is ignored and no mirror logic is synthesized.

Decomposition:
- Package img_fetch_pkg holds:
  - state typedef (S_IDLE, S_LINE, S_ACTIVE);
  - IMG_PIXELS = IMG_W*IMG_H;
  - pipeline depth constant FETCH_LAT=3.
- Sub-module fetch_axis_counter: replication counter plus saturating index, used twice (horizontal and vertical).
  - Ports: clk, rst_n, clr, step, sub_wrap, idx, at_end.

Test Plan:
- Reset then frame_start, sel=0, 640 active cycles on line 0 -> o_addr 0,0,0,0,1,1,1,1,...,159; o_pixel_valid rises exactly 3 cycles after i_active, 640 valid cycles.
- Line 4 of frame with sel=2 -> first o_addr = 2*19200 + 1*160 = 38560; lines 0-3 all start at 38400.
- Active width 700 with SRAM preloaded to 12'hABC -> pixels 0-639 = 12'hABC, pixels 640-699 = 12'h000 and valid.
- i_img_sel changed 1->3 mid-frame -> addresses keep image 1 base until next frame_start, then 57600.
- i_rst_n low for 1 cycle at pixel 300 of a line -> next cycle o_pixel_valid=0 and o_addr=0; no valid pixels until frame_start.
- With IMG_FETCH_MIRROR_EN, mirror=1, sel=0, line 0 -> o_addr sequence 159 x4, 158 x4, ...; without macro the same stimulus gives 0 x4, 1 x4.

Source files
------------

// File: rtl/image_fetch_pkg.sv
// Shared types and constants for the image_fetch scan-out stage.
// Optional feature macro: IMG_FETCH_MIRROR_EN (horizontal mirror).
package img_fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LINE,
    S_ACTIVE
  } state_t;

  localparam int IMG_W_DEF  = 160;
  localparam int IMG_H_DEF  = 120;
  localparam int IMG_PIXELS = IMG_W_DEF * IMG_H_DEF;
  localparam int FETCH_LAT  = 3;

endpackage

// File: rtl/image_fetch_if.sv
// Frame SRAM read bus between image_fetch (master) and the SRAM (slave).
// Optional feature macro: IMG_FETCH_MIRROR_EN (not used here).
interface image_fetch_if #(
  parameter int ADDR_WIDTH = 17,
  parameter int DATA_WIDTH = 12
);
  logic [ADDR_WIDTH-1:0] o_addr;
  logic                  o_write;
  logic [DATA_WIDTH-1:0] i_sram_data;

  modport master (
    output o_addr,
    output o_write,
    input  i_sram_data
  );

  modport slave (
    input  o_addr,
    input  o_write,
    output i_sram_data
  );
endinterface

// File: rtl/image_fetch_axis_counter.sv
// Replication sub-counter plus saturating index for one scan axis.
// Optional feature macro: IMG_FETCH_MIRROR_EN (not used here).
module fetch_axis_counter #(
  parameter int SUB_SHIFT = 2,
  parameter int IDX_W     = 8,
  parameter int IDX_MAX   = 160
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             step,
  output logic             sub_wrap,
  output logic [IDX_W-1:0] idx,
  output logic             at_end
);

  localparam int SW = (SUB_SHIFT > 0) ? SUB_SHIFT : 1;
  localparam logic [SW-1:0] SUB_MAX = SW'((1 << SUB_SHIFT) - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(IDX_MAX);

  logic [SW-1:0]    sub_q, sub_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  assign at_end   = (idx_q == IDX_LAST);
  assign sub_wrap = step && (sub_q == SUB_MAX);
  assign idx      = idx_q;

  always_comb begin
    sub_d = sub_q;
    idx_d = idx_q;
    if (clr) begin
      sub_d = '0;
      idx_d = '0;
    end else if (step) begin
      if (sub_wrap) begin
        sub_d = '0;
        if (!at_end) idx_d = idx_q + 1'b1;
      end else begin
        sub_d = sub_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sub_q <= '0;
      idx_q <= '0;
    end else begin
      sub_q <= sub_d;
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/image_fetch.sv
// VGA scan-out fetch: timing -> SRAM addresses -> aligned pixel stream.
// Optional feature macro: IMG_FETCH_MIRROR_EN (horizontal mirror).
module image_fetch
  import img_fetch_pkg::*;
#(
  parameter int ADDR_WIDTH  = 17,
  parameter int DATA_WIDTH  = 12,
  parameter int IMG_W       = IMG_W_DEF,
  parameter int IMG_H       = IMG_H_DEF,
  parameter int NUM_IMAGES  = 4,
  parameter int SEL_WIDTH   = 2,
  parameter int SCALE_SHIFT = 2,
  parameter logic [DATA_WIDTH-1:0] BORDER_COLOR = 12'h000
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_frame_start,
  input  logic                  i_active,
  input  logic [SEL_WIDTH-1:0]  i_img_sel,
  input  logic                  i_mirror,
  image_fetch_if.master         sram,
  output logic [DATA_WIDTH-1:0] o_pixel,
  output logic                  o_pixel_valid
);

  localparam int AW  = ADDR_WIDTH;
  localparam int PIX = IMG_W * IMG_H;
  localparam int IW  = $clog2(IMG_W + 1);
  localparam int HW  = $clog2(IMG_H + 1);
  localparam int PL  = FETCH_LAT - 1;
  localparam logic [SEL_WIDTH:0] NUM_IMG = (SEL_WIDTH + 1)'(NUM_IMAGES);

  state_t                state_q;
  logic [SEL_WIDTH-1:0]  sel_q;
  logic [AW-1:0]         base_q, base_new;
  logic [AW-1:0]         addr_q, addr_d;
  logic [PL-1:0]         vld_q, brd_q;
  logic [DATA_WIDTH-1:0] pix_q, pix_d;
  logic                  pvld_q;

  logic          live, line_end, border;
  logic          sel_bad, sel_in_bad;
  logic          col_end, row_end, v_wrap;
  logic [IW-1:0] col, col_a;
  logic          col_wrap_unused;
  logic [HW-1:0] row_idx_unused;

  assign live     = i_active && !i_frame_start
                  && (state_q != S_IDLE);
  assign line_end = (state_q == S_ACTIVE) && !i_active
                  && !i_frame_start;

  fetch_axis_counter #(
    .SUB_SHIFT (SCALE_SHIFT),
    .IDX_W     (IW),
    .IDX_MAX   (IMG_W)
  ) u_h (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .clr      (!live),
    .step     (live),
    .sub_wrap (col_wrap_unused),
    .idx      (col),
    .at_end   (col_end)
  );

  fetch_axis_counter #(
    .SUB_SHIFT (SCALE_SHIFT),
    .IDX_W     (HW),
    .IDX_MAX   (IMG_H)
  ) u_v (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .clr      (i_frame_start),
    .step     (line_end),
    .sub_wrap (v_wrap),
    .idx      (row_idx_unused),
    .at_end   (row_end)
  );

  assign sel_bad    = {1'b0, sel_q} >= NUM_IMG;
  assign sel_in_bad = {1'b0, i_img_sel} >= NUM_IMG;
  assign base_new   = sel_in_bad ? '0
                    : AW'(i_img_sel) * AW'(PIX);
  assign border     = col_end || row_end || sel_bad;

`ifdef IMG_FETCH_MIRROR_EN
  logic mir_q;
  assign col_a = mir_q ? (IW'(IMG_W - 1) - col) : col;
`else
  logic mirror_unused;
  assign mirror_unused = i_mirror;
  assign col_a = col;
`endif

  // Border pixels keep the last fetched address on the bus.
  always_comb begin
    addr_d = addr_q;
    if (sel_bad) addr_d = '0;
    else if (live && !border) addr_d = base_q + AW'(col_a);
  end

  always_comb begin
    pix_d = '0;
    if (vld_q[PL-1])
      pix_d = brd_q[PL-1] ? BORDER_COLOR : sram.i_sram_data;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      base_q  <= '0;
      addr_q  <= '0;
      vld_q   <= '0;
      brd_q   <= '0;
      pix_q   <= '0;
      pvld_q  <= 1'b0;
`ifdef IMG_FETCH_MIRROR_EN
      mir_q   <= 1'b0;
`endif
    end else begin
      if (i_frame_start) begin
        state_q <= S_LINE;
        sel_q   <= i_img_sel;
        base_q  <= base_new;
`ifdef IMG_FETCH_MIRROR_EN
        mir_q   <= i_mirror;
`endif
      end else begin
        unique case (state_q)
          S_IDLE:   state_q <= S_IDLE;
          S_LINE:   if (i_active) state_q <= S_ACTIVE;
          S_ACTIVE: if (!i_active) state_q <= S_LINE;
          default:  state_q <= S_IDLE;
        endcase
        if (v_wrap && !row_end)
          base_q <= base_q + AW'(IMG_W);
      end
      addr_q <= addr_d;
      vld_q  <= {vld_q[PL-2:0], live};
      brd_q  <= {brd_q[PL-2:0], border};
      pix_q  <= pix_d;
      pvld_q <= vld_q[PL-1];
    end
  end

  assign sram.o_addr    = addr_q;
  assign sram.o_write   = 1'b0;
  assign o_pixel        = pix_q;
  assign o_pixel_valid  = pvld_q;

endmodule

// File: tb/tb_image_fetch.sv
// Scoreboard bench for image_fetch with a registered-read SRAM model.
// Optional feature macro: IMG_FETCH_MIRROR_EN (mirror expectations).
module tb_image_fetch;

  logic        clk = 1'b0;
  logic        rst_n, fs, act, mir;
  logic [1:0]  sel;
  logic [11:0] pix, sram_q;
  logic        pv;

  always #5 clk = ~clk;

  image_fetch_if #(.ADDR_WIDTH(17), .DATA_WIDTH(12)) bus ();

  image_fetch dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_frame_start (fs),
    .i_active      (act),
    .i_img_sel     (sel),
    .i_mirror      (mir),
    .sram          (bus),
    .o_pixel       (pix),
    .o_pixel_valid (pv)
  );

`ifdef IMG_FETCH_MIRROR_EN
  localparam bit MIR_ON = 1'b1;
`else
  localparam bit MIR_ON = 1'b0;
`endif

  typedef struct {
    logic [11:0] px;
    int          cy;
  } exp_t;

  exp_t        pq[$];
  logic [16:0] aq[$];
  int          checks = 0, failures = 0, cyc = 0, vld_seen = 0;
  bit          frame_ok = 1'b0, act_s = 1'b0, fill = 1'b0;
  int          m_sel = 0, m_line = 0;
  bit          m_mir = 1'b0;
  logic [16:0] last_addr = '0;

  function automatic logic [11:0] memf(input logic [16:0] a);
    return fill ? 12'hABC : (a[11:0] ^ {3'b0, a[16:12], 4'b0});
  endfunction

  // Registered-read SRAM model
  always @(posedge clk) sram_q <= memf(bus.o_addr);
  assign bus.i_sram_data = sram_q;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    act_s <= rst_n && act && frame_ok && !fs;
  end

  always @(negedge clk) begin
    exp_t        e;
    logic [16:0] a;
    if (act_s) begin
      checks++;
      if (aq.size() == 0) begin
        failures++;
        $display("FAIL addr_underflow got=%0d", bus.o_addr);
      end else begin
        a = aq.pop_front();
        if (bus.o_addr !== a) begin
          failures++;
          $display("FAIL addr got=%0d want=%0d t=%0t",
                   bus.o_addr, a, $time);
        end
      end
    end
    if (pv === 1'b1) begin
      vld_seen++;
      checks++;
      if (pq.size() == 0) begin
        failures++;
        $display("FAIL spurious_valid pix=%h t=%0t", pix, $time);
      end else begin
        e = pq.pop_front();
        if (pix !== e.px || (cyc - e.cy) != 3) begin
          failures++;
          $display("FAIL pixel got=%h lat=%0d want=%h lat=3 t=%0t",
                   pix, cyc - e.cy, e.px, $time);
        end
      end
    end
  end

  task automatic chk(input string n, input longint a, input longint e);
    checks++;
    if (a != e) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", n, a, e);
    end
  endtask

  task automatic pixel(input int p);
    int          col, row;
    bit          b;
    logic [16:0] a;
    col = p >> 2;
    row = m_line >> 2;
    b   = (col >= 160) || (row >= 120) || (m_sel >= 4);
    if (m_sel >= 4) a = '0;
    else if (!b)
      a = 17'(m_sel * 19200 + row * 160
              + ((m_mir && MIR_ON) ? 159 - col : col));
    else a = last_addr;
    last_addr = a;
    if (frame_ok) begin
      aq.push_back(a);
      pq.push_back('{px: (b ? 12'h000 : memf(a)), cy: cyc});
    end
  endtask

  task automatic line(input int w, input int gap);
    for (int p = 0; p < w; p++) begin
      @(negedge clk);
      act = 1'b1;
      pixel(p);
    end
    @(negedge clk);
    act = 1'b0;
    m_line++;
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic frame(input int s, input bit m);
    @(negedge clk);
    fs = 1'b1; sel = 2'(s); mir = m;
    m_sel = s; m_mir = m; m_line = 0; frame_ok = 1'b1;
    @(negedge clk);
    fs = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic drain(input string n);
    repeat (6) @(negedge clk);
    chk({n, "_pix_drained"}, pq.size(), 0);
    chk({n, "_addr_drained"}, aq.size(), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0;
    rst_n = 1'b0; fs = 1'b0; act = 1'b0; mir = 1'b0; sel = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_addr", bus.o_addr, 0);
    chk("rst_pixel", pix, 0);
    chk("rst_valid", pv, 0);
    chk("write_low", bus.o_write, 0);
    @(negedge clk);
    rst_n = 1'b1;

    line(20, 4);
    chk("idle_active_ignored", vld_seen, 0);

    frame(0, 1'b0);
    line(640, 6);
    drain("line0_sel0");
    chk("line0_valid_count", vld_seen, 640);

    frame(2, 1'b0);
    for (int l = 0; l < 5; l++) line(640, 6);
    drain("sel2_line4");

    fill = 1'b1;
    frame(0, 1'b0);
    v0 = vld_seen;
    line(700, 6);
    drain("border_700");
    chk("border_valid_count", vld_seen - v0, 700);
    fill = 1'b0;

    frame(1, 1'b0);
    line(640, 6);
    @(negedge clk);
    sel = 2'd3;
    line(640, 6);
    frame(3, 1'b0);
    line(640, 6);
    drain("sel_change");

    frame(0, 1'b0);
    line(640, 6);
    for (int p = 0; p < 300; p++) begin
      @(negedge clk);
      act = 1'b1;
      pixel(p);
    end
    @(negedge clk);
    rst_n = 1'b0;
    frame_ok = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_addr", bus.o_addr, 0);
    chk("midrst_valid", pv, 0);
    chk("midrst_pixel", pix, 0);
    pq.delete();
    aq.delete();
    last_addr = '0;
    v0 = vld_seen;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (339) @(negedge clk);
    act = 1'b0;
    repeat (4) @(negedge clk);
    line(640, 6);
    repeat (6) @(negedge clk);
    chk("no_valid_after_rst", vld_seen - v0, 0);
    frame(0, 1'b0);
    line(16, 4);
    drain("after_rst");

    frame(0, 1'b1);
    line(64, 4);
    drain("mirror");

    frame(3, 1'b0);
    for (int l = 0; l < 484; l++) line(8, 4);
    drain("row_sat");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
